// File: rtl/btn_step_debounce_pkg.sv
// Shared types and timing constants for the push-button step debouncer.
// Board defaults assume the 50 MHz clock; SIM_* values keep simulations short.
package btn_step_debounce_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } state_t;

    localparam int STEP_CNT_W = 16;

    // 10 ms debounce, 0.5 s to first repeat, then 10 steps/s at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;
    localparam int DEF_CNT_W           = 26;

    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY    = 8;
    localparam int SIM_REPEAT_PERIOD   = 3;
    localparam int SIM_CNT_W           = 8;

endpackage

// File: rtl/btn_step_debounce_if.sv
// Button-in / step-out bundle; master drives the raw button, slave is the debouncer.
interface btn_step_debounce_if;
    import btn_step_debounce_pkg::*;

    logic                  btn_raw;
    logic                  step;
    logic                  pressed;
    logic [STEP_CNT_W-1:0] step_count;

    modport master (output btn_raw, input step, pressed, step_count);
    modport slave  (input btn_raw, output step, pressed, step_count);

endinterface

// File: rtl/btn_step_debounce_sync2.sv
// Two-flop synchronizer for slow asynchronous board inputs (keys, switches).
// RST_VAL lets each input reset to its own inactive level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_step_debounce.sv
// Turns a bouncing push-button into one-cycle step strobes (with optional
// auto-repeat) and counts the strobes for the hex display.
module btn_step_debounce
    import btn_step_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              Rst,
    btn_step_debounce_if.slave btn
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t                state, state_nx;
    logic [CNT_W-1:0]      timer, timer_nx;
    logic                  step_q, step_nx;
    logic                  pressed_q, pressed_nx;
    logic [STEP_CNT_W-1:0] cnt_q;
    logic                  sync_q;
    logic                  p;

    // Synchronizer resets to the released level so reset never looks like a press
    sync2 #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (btn.btn_raw),
        .q   (sync_q)
    );

    assign p = ACTIVE_LOW ? ~sync_q : sync_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            timer     <= '0;
            step_q    <= 1'b0;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            step_q    <= step_nx;
            pressed_q <= pressed_nx;
            cnt_q     <= cnt_q + STEP_CNT_W'(step_nx);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (p) state_nx = DEB_PRESS;
            DEB_PRESS:   if (!p) state_nx = IDLE;
                         else if (timer == DEB_LAST) state_nx = HELD;
            HELD:        if (!p) state_nx = DEB_RELEASE;
                         else if (REPEAT_EN && timer == DLY_LAST) state_nx = REPEAT;
            REPEAT:      if (!p) state_nx = DEB_RELEASE;
            DEB_RELEASE: if (p) state_nx = HELD;
                         else if (timer == DEB_LAST) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    // Any state change restarts the single timer; HELD only counts when repeating
    always_comb begin
        timer_nx   = timer;
        pressed_nx = pressed_q;
        if (state_nx != state) begin
            timer_nx = '0;
        end else begin
            case (state)
                DEB_PRESS, DEB_RELEASE: timer_nx = timer + 1'b1;
                HELD:                   if (REPEAT_EN) timer_nx = timer + 1'b1;
                REPEAT:                 timer_nx = (timer == PER_LAST) ? '0 : timer + 1'b1;
                default:                timer_nx = timer;
            endcase
        end

        step_nx = (state == DEB_PRESS && state_nx == HELD)
               || (state == HELD      && state_nx == REPEAT)
               || (state == REPEAT    && state_nx == REPEAT && timer == PER_LAST);

        if (state == DEB_PRESS && state_nx == HELD)
            pressed_nx = 1'b1;
        if (state == DEB_RELEASE && state_nx == IDLE)
            pressed_nx = 1'b0;
    end

    assign btn.step       = step_q;
    assign btn.pressed    = pressed_q;
    assign btn.step_count = cnt_q;

endmodule

// File: tb/tb_btn_step_debounce.sv
// Drives one raw button into two debouncers (repeat off / on) and checks every
// cycle against a run-length model of the press/release/repeat rules.
module tb_btn_step_debounce;
    import btn_step_debounce_pkg::*;

    localparam int D = SIM_DEBOUNCE_CYCLES;
    localparam int R = SIM_REPEAT_DELAY;
    localparam int P = SIM_REPEAT_PERIOD;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic raw = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    btn_step_debounce_if if0 ();
    btn_step_debounce_if if1 ();
    assign if0.btn_raw = raw;
    assign if1.btn_raw = raw;

    btn_step_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .REPEAT_DELAY(R),
        .REPEAT_PERIOD(P), .ACTIVE_LOW(1'b1), .CNT_W(SIM_CNT_W))
        dut0 (.Clk(Clk), .Rst(Rst), .btn(if0.slave));

    btn_step_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .REPEAT_DELAY(R),
        .REPEAT_PERIOD(P), .ACTIVE_LOW(1'b1), .CNT_W(SIM_CNT_W))
        dut1 (.Clk(Clk), .Rst(Rst), .btn(if1.slave));

    always #5 Clk = ~Clk;

    // Model: press accepted after D+1 consecutive pressed samples, release after
    // D+1 consecutive released samples; repeats at hold count R, R+P, R+2P, ...
    bit          r1 = 1'b1, r2 = 1'b1;
    int          run1 [2];
    int          zrun [2];
    int          hold [2];
    bit          dm   [2];
    bit          sm   [2];
    bit          sprev[2];
    logic [15:0] cm   [2];
    bit          rep  [2];

    task automatic model_edge(input bit rst, input bit b);
        bit pp;
        pp = ~r2;
        if (rst) begin
            r1 = 1'b1;
            r2 = 1'b1;
            for (int i = 0; i < 2; i++) begin
                run1[i] = 0; zrun[i] = 0; hold[i] = 0;
                dm[i] = 1'b0; sm[i] = 1'b0; cm[i] = 16'h0000;
            end
            return;
        end
        r2 = r1;
        r1 = b;
        for (int i = 0; i < 2; i++) begin
            sm[i] = 1'b0;
            if (!dm[i]) begin
                run1[i] = pp ? run1[i] + 1 : 0;
                if (run1[i] == D + 1) begin
                    dm[i] = 1'b1; sm[i] = 1'b1; hold[i] = 0; zrun[i] = 0;
                end
            end else if (!pp) begin
                zrun[i]++;
                if (zrun[i] == D + 1) begin
                    dm[i] = 1'b0; run1[i] = 0;
                end
            end else if (zrun[i] > 0) begin
                zrun[i] = 0;
                hold[i] = 0;
            end else begin
                hold[i]++;
                if (rep[i] && (hold[i] == R || (hold[i] > R && (hold[i] - R) % P == 0)))
                    sm[i] = 1'b1;
            end
            cm[i] = cm[i] + 16'(sm[i]);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("step0",    16'(if0.step),    16'(sm[0]));
        chk("pressed0", 16'(if0.pressed), 16'(dm[0]));
        chk("count0",   if0.step_count,   cm[0]);
        chk("step1",    16'(if1.step),    16'(sm[1]));
        chk("pressed1", 16'(if1.pressed), 16'(dm[1]));
        chk("count1",   if1.step_count,   cm[1]);
        chk("adjacent0", 16'(if0.step & sprev[0]), 16'h0);
        chk("adjacent1", 16'(if1.step & sprev[1]), 16'h0);
        sprev[0] = if0.step;
        sprev[1] = if1.step;
    endtask

    task automatic cyc(input bit r, input bit b, input int n);
        repeat (n) begin
            @(negedge Clk);
            Rst = r;
            raw = b;
            @(posedge Clk);
            model_edge(r, b);
            #1;
            check_all();
        end
    endtask

    logic [15:0] c_before;
    int          lat;
    bit          level;

    initial begin
        rep[0] = 1'b0;
        rep[1] = 1'b1;
        sprev[0] = 1'b0;
        sprev[1] = 1'b0;

        // reset with button released, then idle
        cyc(1'b1, 1'b1, 2);
        chk("reset_count", if0.step_count, 16'h0000);
        cyc(1'b0, 1'b1, 50);

        // single clean press and release
        c_before = if0.step_count;
        cyc(1'b0, 1'b0, 20);
        chk("one_press", if0.step_count - c_before, 16'h0001);
        chk("held_level", 16'(if0.pressed), 16'h0001);
        cyc(1'b0, 1'b1, 10);
        chk("released_level", 16'(if0.pressed), 16'h0000);

        // bouncy press and bouncy release
        c_before = if0.step_count;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 2);
            cyc(1'b0, 1'b1, 2);
        end
        cyc(1'b0, 1'b0, 15);
        cyc(1'b0, 1'b1, 2);
        cyc(1'b0, 1'b0, 2);
        cyc(1'b0, 1'b1, 15);
        chk("bounce_one_step", if0.step_count - c_before, 16'h0001);

        // long hold: repeats on dut1 only
        cyc(1'b0, 1'b0, 30);
        cyc(1'b0, 1'b1, 10);

        // wrap from FFFF on the next press
        @(negedge Clk);
        force dut0.cnt_q = 16'hFFFF;
        force dut1.cnt_q = 16'hFFFF;
        #1;
        release dut0.cnt_q;
        release dut1.cnt_q;
        cm[0] = 16'hFFFF;
        cm[1] = 16'hFFFF;
        cyc(1'b0, 1'b1, 2);
        cyc(1'b0, 1'b0, 12);
        chk("wrap0", if0.step_count, 16'h0000);
        cyc(1'b0, 1'b1, 10);

        // reset mid-debounce, then fresh latency measured from reset release
        cyc(1'b0, 1'b0, 4);
        cyc(1'b1, 1'b0, 1);
        chk("rst_mid_deb", if0.step_count, 16'h0000);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cyc(1'b0, 1'b0, 1);
            if (if0.step) lat = i;
        end
        chk("latency", 16'(lat), 16'(D + 3));

        // reset mid-repeat on dut1
        cyc(1'b0, 1'b0, 20);
        cyc(1'b1, 1'b0, 1);
        chk("rst_mid_rep", 16'(if1.pressed), 16'h0000);
        cyc(1'b0, 1'b0, 20);
        cyc(1'b0, 1'b1, 10);

        // randomized bursts, with occasional long holds and resets
        level = 1'b1;
        for (int s = 0; s < 300; s++) begin
            level = ~level;
            if ($urandom_range(0, 49) == 0)
                cyc(1'b1, level, $urandom_range(1, 3));
            else
                cyc(1'b0, level, $urandom_range(1, (s % 5 == 0) ? 40 : 8));
        end
        cyc(1'b0, 1'b1, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
